// File: rtl/cia_serial_pkg.sv
// Shared types and constants for the CIA serial data port (SDR).
package cia;
    localparam int SDR_BITS = 8;

    typedef logic [7:0] reg8_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } sdr_state_t;
endpackage

// File: rtl/cia_serial_if.sv
// CPU-side register interface of the serial port: SDR write/read, mode bit and interrupt.
interface cia_serial_if;
    import cia::*;

    logic  sdr_w;
    reg8_t data;
    logic  spmode;
    reg8_t sdr;
    logic  intr;

    modport master (output sdr_w, data, spmode, input sdr, intr);
    modport slave  (input sdr_w, data, spmode, output sdr, intr);
endinterface

// File: rtl/cia_serial_cnt_filter.sv
// CNT input glitch filter and rising-edge detector, used only with CIA_SERIAL_CNT_FILTER_EN.
module cia_cnt_filter (
    input  logic clk,
    input  logic res_n,
    input  logic phi2_dn,
    input  logic cnt_in,
    output logic rise_o
);
    logic stage1_q, stage2_q, filt_q, filt_d;

    // The filtered level only follows the pin after two identical consecutive samples.
    always_comb begin
        filt_d = filt_q;
        if (stage1_q == stage2_q) begin
            filt_d = stage1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            stage1_q <= 1'b1;
            stage2_q <= 1'b1;
            filt_q   <= 1'b1;
        end else if (phi2_dn) begin
            stage1_q <= cnt_in;
            stage2_q <= stage1_q;
            filt_q   <= filt_d;
        end
    end

    assign rise_o = filt_d & ~filt_q;
endmodule

// File: rtl/cia_serial.sv
// CIA serial data port: shifts bytes out on SP/CNT paced by timer A, or in from external SP/CNT.
// Optional macro CIA_SERIAL_CNT_FILTER_EN adds a 2-sample glitch filter on cnt_in.
module cia_serial
    import cia::*;
#(
    parameter int BITS = SDR_BITS
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        phi2_dn,
    cia_serial_if.slave cpu,
    input  logic        ta_ufl,
    input  logic        cnt_in,
    input  logic        sp_in,
    output logic        cnt_out,
    output logic        cnt_oe,
    output logic        sp_out,
    output logic        sp_oe
);
    localparam logic [3:0] LAST_IN  = 4'(BITS - 1);
    localparam logic [3:0] LAST_OUT = 4'(2 * BITS - 1);

    sdr_state_t state_q, state_d;
    reg8_t      buffer_q, buffer_d;
    reg8_t      shiftReg_q, shiftReg_d;
    reg8_t      wrData;
    logic       full_q, full_d;
    logic [3:0] phase_q, phase_d;
    logic       cntOut_q, cntOut_d;
    logic       spOut_q, spOut_d;
    logic       intr_q, intr_d;
    logic       modePrev_q;
    logic       cntRise;

`ifdef CIA_SERIAL_CNT_FILTER_EN
    cia_cnt_filter u_cntFilter (
        .clk     (clk),
        .res_n   (res_n),
        .phi2_dn (phi2_dn),
        .cnt_in  (cnt_in),
        .rise_o  (cntRise)
    );
`else
    logic cntPrev_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            cntPrev_q <= 1'b1;
        end else if (phi2_dn) begin
            cntPrev_q <= cnt_in;
        end
    end

    assign cntRise = ~cntPrev_q & cnt_in;
`endif

    // A same-cycle write feeds the shifter directly so an idle start never misses fresh data.
    assign wrData = cpu.sdr_w ? cpu.data : buffer_q;

    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        shiftReg_d = shiftReg_q;
        full_d     = full_q;
        phase_d    = phase_q;
        cntOut_d   = cntOut_q;
        spOut_d    = spOut_q;
        intr_d     = 1'b0;

        if (cpu.sdr_w) begin
            buffer_d = cpu.data;
        end

        if (cpu.spmode != modePrev_q) begin
            state_d  = IDLE;
            phase_d  = 4'd0;
            full_d   = 1'b0;
            cntOut_d = 1'b1;
            spOut_d  = 1'b1;
        end else if (cpu.spmode) begin
            if (cpu.sdr_w) begin
                full_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (ta_ufl && (full_q || cpu.sdr_w)) begin
                        shiftReg_d = wrData;
                        full_d     = 1'b0;
                        spOut_d    = wrData[BITS-1];
                        cntOut_d   = 1'b0;
                        phase_d    = 4'd1;
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (ta_ufl) begin
                        phase_d  = phase_q + 4'd1;
                        cntOut_d = ~cntOut_q;
                        // Data moves only as CNT falls, keeping each bit stable over the rising edge.
                        if (cntOut_q) begin
                            shiftReg_d = shiftReg_q << 1;
                            spOut_d    = shiftReg_q[BITS-2];
                        end
                        if (phase_q == LAST_OUT) begin
                            state_d = IDLE;
                            intr_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cntRise) begin
            shiftReg_d = {shiftReg_q[BITS-2:0], sp_in};
            phase_d    = phase_q + 4'd1;
            if (phase_q == LAST_IN) begin
                buffer_d = {shiftReg_q[BITS-2:0], sp_in};
                phase_d  = 4'd0;
                intr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= IDLE;
            buffer_q   <= 8'h00;
            shiftReg_q <= 8'h00;
            full_q     <= 1'b0;
            phase_q    <= 4'd0;
            cntOut_q   <= 1'b1;
            spOut_q    <= 1'b1;
            intr_q     <= 1'b0;
            modePrev_q <= 1'b0;
        end else if (phi2_dn) begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            shiftReg_q <= shiftReg_d;
            full_q     <= full_d;
            phase_q    <= phase_d;
            cntOut_q   <= cntOut_d;
            spOut_q    <= spOut_d;
            intr_q     <= intr_d;
            modePrev_q <= cpu.spmode;
        end
    end

    assign cpu.sdr  = buffer_q;
    assign cpu.intr = intr_q;
    assign cnt_out  = cntOut_q;
    assign sp_out   = spOut_q;
    assign cnt_oe   = cpu.spmode;
    assign sp_oe    = cpu.spmode;
endmodule

// File: tb/tb_cia_serial.sv
// Scoreboard bench for cia_serial: stimulus pushes expected SP bits and interrupt bytes, a monitor pops them.
module tb_cia_serial;
    import cia::*;

    typedef struct {
        reg8_t data;
        int    ufl;
    } intrExp_t;

    logic clk     = 1'b0;
    logic res_n   = 1'b0;
    logic phi2_dn = 1'b0;
    logic ta_ufl  = 1'b0;
    logic cnt_in  = 1'b1;
    logic sp_in   = 1'b0;
    logic cnt_out, cnt_oe, sp_out, sp_oe;

    cia_serial_if busIf ();

    logic     spQ[$];
    intrExp_t intrQ[$];
    int       checks    = 0;
    int       failures  = 0;
    int       uflCount  = 0;
    int       intrSeen  = 0;
    bit       monOn     = 1'b0;
    logic     cntMon    = 1'b1;
    logic     intrMon   = 1'b0;
    reg8_t    glitchExp;

    always #5 clk = ~clk;

    cia_serial dut (
        .clk     (clk),
        .res_n   (res_n),
        .phi2_dn (phi2_dn),
        .cpu     (busIf),
        .ta_ufl  (ta_ufl),
        .cnt_in  (cnt_in),
        .sp_in   (sp_in),
        .cnt_out (cnt_out),
        .cnt_oe  (cnt_oe),
        .sp_out  (sp_out),
        .sp_oe   (sp_oe)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One phi2 cycle: strobes high for one clk with phi2_dn, then one quiet clk.
    task automatic applyStimulus(input logic ufl, input logic wr, input reg8_t d);
        @(negedge clk);
        ta_ufl       = ufl;
        busIf.sdr_w  = wr;
        busIf.data   = d;
        phi2_dn      = 1'b1;
        if (ufl) uflCount++;
        @(negedge clk);
        phi2_dn      = 1'b0;
        ta_ufl       = 1'b0;
        busIf.sdr_w  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic pushByte(input reg8_t v);
        for (int i = 7; i >= 0; i--) spQ.push_back(v[i]);
    endtask

    task automatic pushIntr(input reg8_t v, input int ufl);
        intrExp_t e;
        e.data = v;
        e.ufl  = ufl;
        intrQ.push_back(e);
    endtask

    task automatic sendBit(input logic b);
        sp_in  = b;
        cnt_in = 1'b0;
        idle(4);
        cnt_in = 1'b1;
        idle(4);
    endtask

    task automatic sendByte(input reg8_t v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    // Monitor: every CNT rising edge and every interrupt pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        logic     expBit;
        intrExp_t expIntr;
        if (monOn) begin
            if (!cntMon && cnt_out) begin
                if (spQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spBit: unexpected CNT rise, sp_out=%0b", sp_out);
                end else begin
                    expBit = spQ.pop_front();
                    checkOutput("spBit", 32'(sp_out), 32'(expBit));
                end
            end
            if (!intrMon && busIf.intr) begin
                intrSeen++;
                if (intrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL intr: unexpected pulse, sdr=%0h", busIf.sdr);
                end else begin
                    expIntr = intrQ.pop_front();
                    checkOutput("intrSdr", 32'(busIf.sdr), 32'(expIntr.data));
                    checkOutput("intrUfl", 32'(uflCount), 32'(expIntr.ufl));
                end
            end
        end
        cntMon  = cnt_out;
        intrMon = busIf.intr;
    end

    initial begin
        busIf.sdr_w  = 1'b0;
        busIf.data   = 8'h00;
        busIf.spmode = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstSdr",   32'(busIf.sdr),  32'h00);
        checkOutput("rstCnt",   32'(cnt_out),    32'h1);
        checkOutput("rstSp",    32'(sp_out),     32'h1);
        checkOutput("rstIntr",  32'(busIf.intr), 32'h0);
        checkOutput("rstCntOe", 32'(cnt_oe),     32'h0);
        checkOutput("rstSpOe",  32'(sp_oe),      32'h0);
        res_n = 1'b1;
        monOn = 1'b1;

        $display("[TB] single byte A5 out");
        busIf.spmode = 1'b1;
        idle(2);
        applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("outCntOe", 32'(cnt_oe), 32'h1);
        pushByte(8'hA5);
        pushIntr(8'hA5, uflCount + 16);
        repeat (16) applyStimulus(1'b1, 1'b0, 8'h00);
        idle(3);
        checkOutput("sdrA5", 32'(busIf.sdr), 32'hA5);

        $display("[TB] back-to-back 5A then 3C");
        applyStimulus(1'b0, 1'b1, 8'h5A);
        pushByte(8'h5A);
        pushByte(8'h3C);
        pushIntr(8'h3C, uflCount + 16);
        pushIntr(8'h3C, uflCount + 32);
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h3C);
        repeat (27) applyStimulus(1'b1, 1'b0, 8'h00);
        idle(3);

        $display("[TB] input byte CA");
        busIf.spmode = 1'b0;
        idle(2);
        pushIntr(8'hCA, uflCount);
        sendByte(8'hCA);
        idle(2);
        checkOutput("sdrCA", 32'(busIf.sdr), 32'hCA);

        $display("[TB] abort after 5 underflows");
        busIf.spmode = 1'b1;
        idle(2);
        applyStimulus(1'b0, 1'b1, 8'hF0);
        spQ.push_back(1'b1);
        spQ.push_back(1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 8'h00);
        spQ.push_back(1'b1);
        busIf.spmode = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abortCnt",  32'(cnt_out),    32'h1);
        checkOutput("abortIntr", 32'(busIf.intr), 32'h0);
        checkOutput("abortSdr",  32'(busIf.sdr),  32'hF0);
        idle(2);
        pushIntr(8'h69, uflCount);
        sendByte(8'h69);
        idle(2);
        checkOutput("sdr69", 32'(busIf.sdr), 32'h69);

        $display("[TB] reset mid-transfer");
        busIf.spmode = 1'b1;
        idle(2);
        applyStimulus(1'b0, 1'b1, 8'h81);
        spQ.push_back(1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
        spQ.push_back(1'b1);
        res_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstCnt",  32'(cnt_out),    32'h1);
        checkOutput("midRstSp",   32'(sp_out),     32'h1);
        checkOutput("midRstIntr", 32'(busIf.intr), 32'h0);
        checkOutput("midRstSdr",  32'(busIf.sdr),  32'h00);
        res_n = 1'b1;
        idle(2);

        $display("[TB] one-cycle CNT glitch then byte 1E");
        busIf.spmode = 1'b0;
        cnt_in = 1'b0;
        sp_in  = 1'b0;
        idle(4);
        sp_in  = 1'b1;
        cnt_in = 1'b1;
        idle(1);
        cnt_in = 1'b0;
        idle(4);
`ifdef CIA_SERIAL_CNT_FILTER_EN
        glitchExp = 8'h1E;
`else
        glitchExp = 8'h8F;
`endif
        pushIntr(glitchExp, uflCount);
        sendByte(8'h1E);
        idle(3);
        checkOutput("sdrGlitch", 32'(busIf.sdr), 32'(glitchExp));

        checkOutput("spQueueLeft",   32'(spQ.size()),   32'h0);
        checkOutput("intrQueueLeft", 32'(intrQ.size()), 32'h0);
        checkOutput("intrCount",     32'(intrSeen),     32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cia_serial.md
Name: cia_serial

Overview:
- Serial data port (SDR) for the CIA: shifts bytes out on SP/CNT, clocked by timer A underflows, and shifts bytes in from an external SP/CNT pair.
- Consumes the timer A underflow strobe (`ta_ufl`) that the timer block produces. Its output interrupt feeds the interrupt control register as the SP source.
- Register access is PHI2-qualified, like the rest of the chip.

Parameters:
- BITS, 8, bits per transfer; only 8 is supported for CIA compatibility.

Ports:
- clk  in  1  system clock
- res_n  in  1  reset; synchronous, active-low, acts on any clk edge regardless of phi2_dn
- phi2_dn  in  1  falling edge of PHI2 (cycle enable); all state advances only when this is high
- sdr_w  in  1  CPU write strobe for the SDR register
- data  in  8  CPU write data
- spmode  in  1  CRA bit 6: 0 = input, 1 = output
- ta_ufl  in  1  timer A underflow, combinational from the timer, valid during phi2_dn
- cnt_in  in  1  CNT pin input
- sp_in  in  1  SP pin input
- sdr  out  8  SDR read value
- cnt_out  out  1  CNT pin drive value
- cnt_oe  out  1  CNT output enable; equals spmode
- sp_out  out  1  SP pin drive value
- sp_oe  out  1  SP output enable; equals spmode
- intr  out  1  SP interrupt; one-phi2-cycle pulse

Behaviour:
- Reset values (res_n = 0): buffer = 8'h00, shift register = 0, full = 0, phase = 0, state IDLE, cnt_out = 1, sp_out = 1, intr = 0, cnt_prev = 1.
- State machine: IDLE, SHIFT; phase counter 4 bits (0..15); one event per phi2_dn.
- Output mode, loading:
  - sdr_w with spmode = 1 sets buffer <= data and full <= 1.
- Output mode, start:
  - Condition: IDLE, full = 1 and ta_ufl.
  - Shift register <= buffer, full <= 0, sp_out <= bit 7, cnt_out <= 0, phase <= 1, go to SHIFT.
  - If sdr_w and ta_ufl occur in the same cycle while IDLE, the new data is shifted (write bypass).
- Output mode, SHIFT: on each ta_ufl, cnt_out toggles and phase increments.
  - On odd-to-even transitions (CNT rising), no data change.
  - On each CNT falling edge, shift left and put the next bit on sp_out. Bits are sent MSB first; each bit is stable across the CNT rising edge.
  - At the 16th underflow (CNT returns high, phase wraps to 0): go to IDLE and set intr = 1 on the next cycle.
  - If full = 1 at that point, the next ta_ufl starts the next byte with no gap.
- Input mode sampling:
  - cnt_in is sampled once per phi2_dn; a rising edge is cnt_prev = 0 and sample = 1.
  - On each rising edge: shift register <= {sr[6:0], sp_in}, phase += 1.
  - On the 8th edge: buffer <= the completed byte, count clears, intr pulses the next cycle.
  - sdr_w in input mode writes buffer only; it does not set full and does not transmit.
- sdr always returns buffer.
- A spmode change aborts any transfer:
  - state goes to IDLE, phase = 0, full = 0, cnt_out = 1, sp_out = 1;
  - buffer is kept and no interrupt is raised.
- Mid-transfer writes in output mode only update buffer and full; the active shift is unaffected. A write while full = 1 overwrites the pending byte.
- intr is high for exactly one phi2 cycle per completed byte. Back-to-back bytes give separate pulses 16 underflows apart.

Optional Feature:
- Macro: CIA_SERIAL_CNT_FILTER_EN.
- Defined: cnt_in passes through a 2-stage filter. The filtered CNT changes only after 2 consecutive identical phi2 samples, and edges are detected on the filtered value. This adds 2 cycles of input latency and rejects 1-cycle glitches.
- Undefined: edge detection uses the single sample directly; a 1-cycle glitch counts as an edge.

Decomposition:
- Package `cia` gains `sdr_state_t` (IDLE, SHIFT) and `SDR_BITS = 8`. It reuses `cia::reg8_t` for data, sdr and buffer.
- Sub-module `cia_cnt_filter`: the filter and edge detector, instantiated only under the macro; with the macro undefined, a plain register is used instead.

Test Plan:
- Reset, then spmode = 1 and write 8'hA5, then 16 ta_ufl pulses:
  - sp_out carries 1,0,1,0,0,1,0,1 at the CNT rising edges;
  - cnt_out shows 8 low/high periods;
  - intr pulses once after the 16th underflow, and sdr = 8'hA5.
- Output mode, write 8'h3C during the first byte's transfer:
  - the second byte starts at the 17th ta_ufl with no idle gap;
  - two intr pulses occur, 16 underflows apart.
- Input mode, drive sp_in = 1,1,0,0,1,0,1,0 on 8 cnt_in rising edges → sdr = 8'hCA and one intr pulse.
- Switch spmode 1→0 after 5 underflows → cnt_out = 1, no intr; a subsequent full input byte is received correctly.
- Assert res_n = 0 mid-transfer without phi2_dn → all outputs return to reset values the next clk.
- With CIA_SERIAL_CNT_FILTER_EN, a 1-cycle cnt_in high glitch does not shift. With the macro undefined, the same glitch shifts one bit.
